rf_wb_sched: RTL

Register-file hazard scoreboard and write-port scheduler for the pipelined core. It tracks which architectural registers have a write in flight and stalls issue on RAW and WAW hazards. It arbitrates the single RF write port between the in-order pipeline writeback and a multi-cycle long-latency unit (divider/MMIO load). It drives the RF write port (we/wR/wD) through one register stage.

---
 rtl/rf_wb_sched_pkg.sv | 20 ++
 rtl/rf_busy_table.sv | 55 +++++
 rtl/rf_wb_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the register-file hazard scoreboard and its
// write-port scheduler.
//   REG_AW   - architectural register address width
//   NUM_REGS - number of architectural registers
//   X0       - the hardwired zero register
//   wb_src_e - which source owns the RF write port in a given cycle
package rf_wb_sched_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_PIPE = 2'd1,
        WB_LU   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_busy_table.sv
// Per-register in-flight bitmap.
// A bit is set when a writing instruction issues and cleared when its result
// is written into the register file. x0 can never be busy.
//   clk, rst           - clock, synchronous active-high reset
//   set_en/set_addr    - mark a register as having a write in flight
//   clr_en/clr_addr    - mark a register's write as complete
//   rs1/rs2/rd_addr    - read port addresses
//   rs1/rs2/rd_busy    - read port results (from the registered bitmap)
//   busy               - full registered bitmap
module rf_busy_table
    import rf_wb_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    input  logic [REG_AW-1:0]   rd_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                rd_busy,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_next;

    // The set is applied after the clear so that a same-edge set and clear
    // of one register leaves it busy; bit 0 is forced low last.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign rd_busy  = busy[rd_addr];

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file hazard scoreboard and write-port scheduler.
// Stalls issue on RAW/WAW hazards and on a full long-latency unit, arbitrates
// the single RF write port (pipeline writeback always wins over the long
// unit) and drives the RF write port through one register stage.
//   clk, rst                      - clock, synchronous active-high reset
//   issue_*                       - decode-stage issue handshake and operands
//   pipe_wb_*                     - unstallable pipeline writeback
//   lu_wb_*                       - long-latency unit writeback handshake
//   rf_we, rf_wR, rf_wD           - registered RF write port
//   busy                          - per-register in-flight bitmap
//   lu_cnt                        - outstanding long-latency operations
//   err                           - sticky protocol error
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int MAX_LU = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [REG_AW-1:0]   issue_rs1,
    input  logic [REG_AW-1:0]   issue_rs2,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                issue_we,
    input  logic                issue_long,
    input  logic                pipe_wb_valid,
    input  logic [REG_AW-1:0]   pipe_wb_rd,
    input  logic [DATA_W-1:0]   pipe_wb_data,
    input  logic                lu_wb_valid,
    output logic                lu_wb_ready,
    input  logic [REG_AW-1:0]   lu_wb_rd,
    input  logic [DATA_W-1:0]   lu_wb_data,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_wR,
    output logic [DATA_W-1:0]   rf_wD,
    output logic [NUM_REGS-1:0] busy,
    output logic [2:0]          lu_cnt,
    output logic                err
);

    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              lu_full;
    logic              issue_fire;
    logic              lu_accept;
    logic              busy_set;
    wb_src_e           wb_src;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              err_event;

    assign busy_set = issue_fire && issue_we && (issue_rd != X0);

    rf_busy_table u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (busy_set),
        .set_addr (issue_rd),
        .clr_en   (rf_we),
        .clr_addr (rf_wR),
        .rs1_addr (issue_rs1),
        .rs2_addr (issue_rs2),
        .rd_addr  (issue_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy     (busy)
    );

    // Hazards are judged only against registered state; a register whose
    // write is landing this cycle is still treated as busy.
    assign lu_full     = (lu_cnt == 3'(MAX_LU));
    assign issue_ready = !rst && !rs1_busy && !rs2_busy
                         && !(issue_we && (issue_rd != X0) && rd_busy)
                         && !(issue_long && lu_full);
    assign issue_fire  = issue_valid && issue_ready;

    // The pipeline writeback cannot be held off, so the long unit only gets
    // the port in cycles where the pipeline is silent.
    assign lu_wb_ready = !rst && !pipe_wb_valid;
    assign lu_accept   = lu_wb_valid && lu_wb_ready;

    always_comb begin
        wb_src  = WB_NONE;
        wb_rd   = X0;
        wb_data = '0;
        if (pipe_wb_valid) begin
            wb_src  = WB_PIPE;
            wb_rd   = pipe_wb_rd;
            wb_data = pipe_wb_data;
        end else if (lu_accept) begin
            wb_src  = WB_LU;
            wb_rd   = lu_wb_rd;
            wb_data = lu_wb_data;
        end
    end

    // Writes to x0 are accepted but never reach the RF.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wR <= '0;
            rf_wD <= '0;
        end else if (wb_src != WB_NONE) begin
            rf_we <= (wb_rd != X0);
            rf_wR <= wb_rd;
            rf_wD <= wb_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // A long issue and a long writeback in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt <= '0;
        end else begin
            case ({issue_fire && issue_long, lu_accept})
                2'b10:   lu_cnt <= lu_cnt + 3'd1;
                2'b01:   if (lu_cnt != 3'd0) lu_cnt <= lu_cnt - 3'd1;
                default: lu_cnt <= lu_cnt;
            endcase
        end
    end

    // Writebacks nobody is waiting for, long results with nothing
    // outstanding, and two sources racing for one register are all flagged.
    assign err_event = ((wb_src != WB_NONE) && (wb_rd != X0) && !busy[wb_rd])
                       || (lu_accept && (lu_cnt == 3'd0))
                       || (pipe_wb_valid && lu_wb_valid && (pipe_wb_rd == lu_wb_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end
    end

endmodule
